// File: rtl/fpcvt_pipe.sv
// Handshaked two's-complement to S/E/F converter with iterative, one-shift-per-cycle normalisation.
// Optional FPCVT_RNE_EN selects round-to-nearest-even; the default build rounds half-up.
module fpcvt_pipe #(
  parameter int IN_W   = 12,
  parameter int EXP_W  = 3,
  parameter int MANT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   D,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              S,
  output logic [EXP_W-1:0]  E,
  output logic [MANT_W-1:0] F,
  output logic              sat
);

  localparam int MW = IN_W - 1;
  localparam int RB = IN_W - 2 - MANT_W;
  localparam logic [EXP_W-1:0]  EMAX    = EXP_W'(IN_W - 1 - MANT_W);
  localparam logic [MW-1:0]     MAG_ONE = MW'(1);
  localparam logic [MANT_W-1:0] F_HALF  = MANT_W'(1) << (MANT_W - 1);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t             state_q;
  logic               sign_q;
  logic [MW-1:0]      mag_q;
  logic [EXP_W-1:0]   exp_q;
  logic               sat_pend_q;
  logic               s_q;
  logic [EXP_W-1:0]   e_q;
  logic [MANT_W-1:0]  f_q;
  logic               sat_q;
  logic               out_valid_q;

  logic               is_min;
  logic [MW-1:0]      mag_d;
  logic [MANT_W-1:0]  f_cur;
  logic               r_cur;
  logic               inc;
  logic [MANT_W-1:0]  f_d;
  logic [EXP_W-1:0]   e_d;
  logic               ovf_d;

`ifdef FPCVT_RNE_EN
  localparam logic [MW-1:0] LOW_MASK = MW'((64'd1 << RB) - 64'd1);
  logic st;
`endif

  always_comb begin
    is_min = D[IN_W-1] && (D[IN_W-2:0] == '0);
    if (is_min)         mag_d = '1;
    else if (D[IN_W-1]) mag_d = ~D[IN_W-2:0] + MAG_ONE;
    else                mag_d = D[IN_W-2:0];

    f_cur = mag_q[MW-1 -: MANT_W];
    r_cur = mag_q[RB];
`ifdef FPCVT_RNE_EN
    st  = |(mag_q & LOW_MASK);
    inc = r_cur && (st || f_cur[0]);
`else
    inc = r_cur;
`endif

    f_d   = f_cur + MANT_W'(inc);
    e_d   = exp_q;
    ovf_d = 1'b0;
    // Carry out of the significand renormalises to 1.00..0 one exponent up, or clamps at EMAX.
    if (inc && (f_cur == '1)) begin
      if (exp_q < EMAX) begin
        f_d = F_HALF;
        e_d = exp_q + EXP_W'(1);
      end else begin
        f_d   = '1;
        e_d   = EMAX;
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      exp_q       <= '0;
      sat_pend_q  <= 1'b0;
      s_q         <= 1'b0;
      e_q         <= '0;
      f_q         <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q     <= D[IN_W-1];
            mag_q      <= mag_d;
            sat_pend_q <= is_min;
            exp_q      <= EMAX;
            state_q    <= NORM;
          end
        end
        NORM: begin
          if (mag_q[MW-1] || (exp_q == '0)) begin
            state_q <= ROUND;
          end else begin
            mag_q <= {mag_q[MW-2:0], 1'b0};
            exp_q <= exp_q - EXP_W'(1);
          end
        end
        ROUND: begin
          s_q         <= sign_q;
          e_q         <= e_d;
          f_q         <= f_d;
          sat_q       <= ovf_d || sat_pend_q;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign S         = s_q;
  assign E         = e_q;
  assign F         = f_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_fpcvt_pipe.sv
// Directed self-checking bench for fpcvt_pipe at default parameters (IN_W=12, EXP_W=3, MANT_W=4).
module tb_fpcvt_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] D = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        S;
  logic [2:0]  E;
  logic [3:0]  F;
  logic        sat;

  int checks = 0;
  int errors = 0;

  fpcvt_pipe #(.IN_W(12), .EXP_W(3), .MANT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .D(D),
    .out_valid(out_valid), .out_ready(out_ready), .S(S), .E(E), .F(F), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic convert(input string tag, input logic [11:0] d, input logic s_e,
                         input logic [2:0] e_e, input logic [3:0] f_e, input logic sat_e,
                         input int lat_e);
    int n;
    @(negedge clk);
    D = d; in_valid = 1'b1;
    check({tag, ".in_ready_idle"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    D = 12'h5A5;
    check({tag, ".in_ready_busy"}, in_ready, 0);
    wait_valid(n);
    check({tag, ".latency"}, n, lat_e);
    check({tag, ".S"}, S, s_e);
    check({tag, ".E"}, E, e_e);
    check({tag, ".F"}, F, f_e);
    check({tag, ".sat"}, sat, sat_e);
    @(posedge clk); #1;
    check({tag, ".out_valid_drop"}, out_valid, 0);
    check({tag, ".in_ready_back"}, in_ready, 1);
  endtask

  initial begin
    int n;
    logic [3:0] f_rne;

    #12;
    check("rst.out_valid", out_valid, 0);
    check("rst.S", S, 0);
    check("rst.E", E, 0);
    check("rst.F", F, 0);
    check("rst.sat", sat, 0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("rst.in_ready", in_ready, 1);

    convert("d00a", 12'h00A, 1'b0, 3'd0, 4'd10, 1'b0, 9);
    convert("d1a6", 12'h1A6, 1'b0, 3'd5, 4'd13, 1'b0, 4);
    convert("d07d", 12'h07D, 1'b0, 3'd4, 4'd8,  1'b0, 6);
    convert("df83", 12'hF83, 1'b1, 3'd4, 4'd8,  1'b0, 6);

    // Abort a conversion in NORM; outputs from df83 must clear at once.
    @(negedge clk); D = 12'h00A; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort.out_valid", out_valid, 0);
    check("abort.S", S, 0);
    check("abort.E", E, 0);
    check("abort.F", F, 0);
    check("abort.sat", sat, 0);
    @(negedge clk); rst_n = 1'b1;
    convert("after_abort", 12'h1A6, 1'b0, 3'd5, 4'd13, 1'b0, 4);

    convert("d800", 12'h800, 1'b1, 3'd7, 4'd15, 1'b0 | 1'b1, 2);
    convert("d7ff", 12'h7FF, 1'b0, 3'd7, 4'd15, 1'b1, 2);
`ifdef FPCVT_RNE_EN
    f_rne = 4'd10;
`else
    f_rne = 4'd11;
`endif
    convert("d0a8", 12'h0A8, 1'b0, 3'd4, f_rne, 1'b0, 5);

    // Back-pressure: hold results in DONE while a second request is offered.
    @(negedge clk); out_ready = 1'b0; D = 12'h1A6; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    wait_valid(n);
    check("stall.latency", n, 4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); D = 12'h00A; in_valid = 1'b1;
      @(posedge clk); #1;
      check("stall.out_valid", out_valid, 1);
      check("stall.in_ready", in_ready, 0);
      check("stall.E", E, 5);
      check("stall.F", F, 13);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("release.out_valid", out_valid, 0);
    check("release.in_ready", in_ready, 1);
    @(posedge clk); #1;
    check("ignored.out_valid", out_valid, 0);
    check("ignored.in_ready", in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
